// File: rtl/adbg_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adbg_tap_ctrl_if
// Purpose  : JTAG pin and debug-unit strobe bundle for the TAP controller.
// Revision : 1.0
// ============================================================================
interface adbg_tap_ctrl_if;
   logic tms_i;
   logic tdi_i;
   logic tdo_o;
   logic tdo_oe_o;
   logic debug_tdo_i;
   logic test_logic_reset_o;
   logic run_test_idle_o;
   logic shift_dr_o;
   logic pause_dr_o;
   logic update_dr_o;
   logic capture_dr_o;
   logic debug_select_o;

   modport master (
      output tms_i, tdi_i, debug_tdo_i,
      input  tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
             shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, debug_select_o
   );

   modport slave (
      input  tms_i, tdi_i, debug_tdo_i,
      output tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
             shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, debug_select_o
   );
endinterface
`default_nettype wire

// File: rtl/adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adbg_tap_ctrl
// Purpose  : IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers.
// Revision : 1.0
// ============================================================================
module adbg_tap_ctrl #(
   parameter int                IR_LEN       = 4,
   parameter logic [31:0]       IDCODE_VALUE = 32'h249511C3,
   parameter logic [IR_LEN-1:0] IDCODE_INSTR = 4'b0010,
   parameter logic [IR_LEN-1:0] DEBUG_INSTR  = 4'b1000,
   parameter logic [IR_LEN-1:0] BYPASS_INSTR = 4'b1111
) (
   input  logic               tck_i,
   input  logic               trst_i,
   adbg_tap_ctrl_if.slave     jtag
);

   localparam logic [IR_LEN-1:0] c_ir_capture = IR_LEN'(5);

   typedef enum logic [3:0] {
      ST_TLR     = 4'd0,
      ST_RTI     = 4'd1,
      ST_SEL_DR  = 4'd2,
      ST_CAP_DR  = 4'd3,
      ST_SH_DR   = 4'd4,
      ST_EX1_DR  = 4'd5,
      ST_PA_DR   = 4'd6,
      ST_EX2_DR  = 4'd7,
      ST_UPD_DR  = 4'd8,
      ST_SEL_IR  = 4'd9,
      ST_CAP_IR  = 4'd10,
      ST_SH_IR   = 4'd11,
      ST_EX1_IR  = 4'd12,
      ST_PA_IR   = 4'd13,
      ST_EX2_IR  = 4'd14,
      ST_UPD_IR  = 4'd15
   } tap_state_t;

   tap_state_t        r_state;
   tap_state_t        w_next_state;
   logic [IR_LEN-1:0] r_ir_shift;
   logic [IR_LEN-1:0] r_ir;
   logic [31:0]       r_idcode_shift;
   logic              r_bypass;
   logic              w_sel_idcode;
   logic              w_sel_debug;
   logic              w_dr_tdo;
   logic              r_tdo;
   logic              r_tdo_oe;

   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         r_state <= ST_TLR;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_TLR:    w_next_state = jtag.tms_i ? ST_TLR    : ST_RTI;
         ST_RTI:    w_next_state = jtag.tms_i ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: w_next_state = jtag.tms_i ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: w_next_state = jtag.tms_i ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  w_next_state = jtag.tms_i ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: w_next_state = jtag.tms_i ? ST_UPD_DR : ST_PA_DR;
         ST_PA_DR:  w_next_state = jtag.tms_i ? ST_EX2_DR : ST_PA_DR;
         ST_EX2_DR: w_next_state = jtag.tms_i ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: w_next_state = jtag.tms_i ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: w_next_state = jtag.tms_i ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: w_next_state = jtag.tms_i ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  w_next_state = jtag.tms_i ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: w_next_state = jtag.tms_i ? ST_UPD_IR : ST_PA_IR;
         ST_PA_IR:  w_next_state = jtag.tms_i ? ST_EX2_IR : ST_PA_IR;
         ST_EX2_IR: w_next_state = jtag.tms_i ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: w_next_state = jtag.tms_i ? ST_SEL_DR : ST_RTI;
         default:   w_next_state = ST_TLR;
      endcase
   end

   assign w_sel_idcode = (r_ir == IDCODE_INSTR);
   assign w_sel_debug  = (r_ir == DEBUG_INSTR);

   // The latched IR only moves in Test-Logic-Reset and on leaving Update-IR.
   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         r_ir           <= IDCODE_INSTR;
         r_ir_shift     <= '0;
         r_idcode_shift <= '0;
         r_bypass       <= 1'b0;
      end else begin
         case (r_state)
            ST_TLR:    r_ir       <= IDCODE_INSTR;
            ST_CAP_IR: r_ir_shift <= c_ir_capture;
            ST_SH_IR:  r_ir_shift <= {jtag.tdi_i, r_ir_shift[IR_LEN-1:1]};
            ST_UPD_IR: r_ir       <= r_ir_shift;
            ST_CAP_DR: begin
               r_bypass <= 1'b0;
               if (w_sel_idcode) begin
                  r_idcode_shift <= IDCODE_VALUE;
               end
            end
            ST_SH_DR: begin
               r_bypass <= jtag.tdi_i;
               if (w_sel_idcode) begin
                  r_idcode_shift <= {jtag.tdi_i, r_idcode_shift[31:1]};
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_dr_tdo = r_bypass;
      if (w_sel_idcode) begin
         w_dr_tdo = r_idcode_shift[0];
      end else if (w_sel_debug) begin
         w_dr_tdo = jtag.debug_tdo_i;
      end
   end

   // TDO launches on the falling edge so the far end samples it mid-cycle.
   always_ff @(negedge tck_i) begin
      if (trst_i) begin
         r_tdo    <= 1'b0;
         r_tdo_oe <= 1'b0;
      end else begin
         case (r_state)
            ST_SH_IR: begin
               r_tdo    <= r_ir_shift[0];
               r_tdo_oe <= 1'b1;
            end
            ST_SH_DR: begin
               r_tdo    <= w_dr_tdo;
               r_tdo_oe <= 1'b1;
            end
            default: begin
               r_tdo    <= 1'b0;
               r_tdo_oe <= 1'b0;
            end
         endcase
      end
   end

   assign jtag.tdo_o              = r_tdo;
   assign jtag.tdo_oe_o           = r_tdo_oe;
   assign jtag.test_logic_reset_o = (r_state == ST_TLR);
   assign jtag.run_test_idle_o    = (r_state == ST_RTI);
   assign jtag.shift_dr_o         = (r_state == ST_SH_DR);
   assign jtag.pause_dr_o         = (r_state == ST_PA_DR);
   assign jtag.update_dr_o        = (r_state == ST_UPD_DR);
   assign jtag.capture_dr_o       = (r_state == ST_CAP_DR);
   assign jtag.debug_select_o     = w_sel_debug;

endmodule
`default_nettype wire

// File: tb/tb_adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adbg_tap_ctrl
// Purpose  : Directed bench for adbg_tap_ctrl with a TDO scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_adbg_tap_ctrl;

   logic tck;
   logic trst;
   int   errors;
   int   checks;
   logic exp_q[$];
   logic [31:0] idv;
   logic [3:0]  capv;

   adbg_tap_ctrl_if tap_if ();

   adbg_tap_ctrl u_dut (
      .tck_i  (tck),
      .trst_i (trst),
      .jtag   (tap_if)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One TCK cycle; returns just after the falling edge so state and TDO are settled.
   task automatic tick(input logic tms, input logic tdi);
      tap_if.tms_i = tms;
      tap_if.tdi_i = tdi;
      @(posedge tck);
      #1;
      @(negedge tck);
      #1;
   endtask

   task automatic chk_tdo(input string tag);
      logic e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%b expected=<empty queue>", tag, tap_if.tdo_o);
      end else begin
         e = exp_q.pop_front();
         chk(tag, tap_if.tdo_o, e);
      end
      chk({tag, "_oe"}, tap_if.tdo_oe_o, 1'b1);
   endtask

   // From Run-Test/Idle: load a new instruction, ending back in Run-Test/Idle.
   task automatic ir_scan(input logic [3:0] ir);
      for (int k = 0; k < 4; k++) exp_q.push_back(capv[k]);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int k = 0; k <= 4; k++) begin
         tick(k == 4, (k > 0) ? ir[k-1] : 1'b0);
         if (k < 4) chk_tdo("ir_tdo");
         else       chk("ir_exit_oe", tap_if.tdo_oe_o, 1'b0);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("ir_rti", tap_if.run_test_idle_o, 1'b1);
   endtask

   // From Run-Test/Idle: scan n DR bits; caller has queued the expected TDO bits.
   task automatic dr_scan(input int n, input logic [31:0] tdi_bits, input logic [31:0] dbg_bits);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("dr_capture", tap_if.capture_dr_o, 1'b1);
      for (int k = 0; k <= n; k++) begin
         tap_if.debug_tdo_i = (k < n) ? dbg_bits[k] : 1'b0;
         tick(k == n, (k > 0) ? tdi_bits[k-1] : 1'b0);
         if (k < n) begin
            chk_tdo("dr_tdo");
            chk("dr_shift", tap_if.shift_dr_o, 1'b1);
         end else begin
            chk("dr_exit_oe", tap_if.tdo_oe_o, 1'b0);
            chk("dr_exit_shift", tap_if.shift_dr_o, 1'b0);
         end
      end
      tick(1'b1, 1'b0);
      chk("dr_update", tap_if.update_dr_o, 1'b1);
      tick(1'b0, 1'b0);
      chk("dr_rti", tap_if.run_test_idle_o, 1'b1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idv  = 32'h249511C3;
      capv = 4'b0101;
      trst = 1'b1;
      tap_if.tms_i = 1'b0;
      tap_if.tdi_i = 1'b0;
      tap_if.debug_tdo_i = 1'b0;

      // Reset state
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("rst_tlr",    tap_if.test_logic_reset_o, 1'b1);
      chk("rst_dsel",   tap_if.debug_select_o, 1'b0);
      chk("rst_oe",     tap_if.tdo_oe_o, 1'b0);
      chk("rst_tdo",    tap_if.tdo_o, 1'b0);
      chk("rst_rti",    tap_if.run_test_idle_o, 1'b0);
      chk("rst_shift",  tap_if.shift_dr_o, 1'b0);
      chk("rst_cap",    tap_if.capture_dr_o, 1'b0);
      chk("rst_upd",    tap_if.update_dr_o, 1'b0);
      chk("rst_pause",  tap_if.pause_dr_o, 1'b0);
      trst = 1'b0;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      chk("tms_tlr",  tap_if.test_logic_reset_o, 1'b1);
      chk("tms_dsel", tap_if.debug_select_o, 1'b0);
      chk("tms_oe",   tap_if.tdo_oe_o, 1'b0);

      // IDCODE read straight out of reset
      tick(1'b0, 1'b0);
      chk("rti", tap_if.run_test_idle_o, 1'b1);
      for (int k = 0; k < 32; k++) exp_q.push_back(idv[k]);
      dr_scan(32, 32'h0, 32'h0);

      // BYPASS: tdi 1,0,1,1 appears one bit late behind the captured 0
      ir_scan(4'b1111);
      chk("byp_dsel", tap_if.debug_select_o, 1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      dr_scan(4, 32'b1101, 32'h0);

      // DEBUG: walk the DR column, then a scan that echoes debug_tdo_i
      ir_scan(4'b1000);
      chk("dbg_dsel", tap_if.debug_select_o, 1'b1);
      tick(1'b1, 1'b0);
      chk("col_seldr_cap", tap_if.capture_dr_o, 1'b0);
      tick(1'b0, 1'b0);
      chk("col_cap", tap_if.capture_dr_o, 1'b1);
      chk("col_cap_sh", tap_if.shift_dr_o, 1'b0);
      tap_if.debug_tdo_i = 1'b1;
      exp_q.push_back(1'b1);
      tick(1'b0, 1'b0);
      chk("col_sh", tap_if.shift_dr_o, 1'b1);
      chk("col_sh_cap", tap_if.capture_dr_o, 1'b0);
      chk_tdo("col_tdo");
      tick(1'b1, 1'b0);
      chk("col_ex1_sh", tap_if.shift_dr_o, 1'b0);
      tick(1'b0, 1'b0);
      chk("col_pause", tap_if.pause_dr_o, 1'b1);
      chk("col_pause_sh", tap_if.shift_dr_o, 1'b0);
      tick(1'b1, 1'b0);
      chk("col_ex2_pause", tap_if.pause_dr_o, 1'b0);
      tick(1'b1, 1'b0);
      chk("col_upd", tap_if.update_dr_o, 1'b1);
      chk("col_upd_pause", tap_if.pause_dr_o, 1'b0);
      tick(1'b0, 1'b0);
      chk("col_rti_upd", tap_if.update_dr_o, 0);
      chk("col_dsel_hold", tap_if.debug_select_o, 1'b1);
      for (int k = 0; k < 6; k++) exp_q.push_back(k[0] ? 1'b0 : 1'b1);
      dr_scan(6, 32'h0, 32'b010101);

      // Unlisted opcode falls back to BYPASS
      ir_scan(4'b0110);
      chk("unl_dsel", tap_if.debug_select_o, 1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      dr_scan(4, 32'b0110, 32'hFFFF_FFFF);

      // Reset during a debug Shift-DR
      ir_scan(4'b1000);
      chk("abort_dsel", tap_if.debug_select_o, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("abort_pre_sh", tap_if.shift_dr_o, 1'b1);
      trst = 1'b1;
      tick(1'b0, 1'b0);
      chk("abort_sh",   tap_if.shift_dr_o, 1'b0);
      chk("abort_tlr",  tap_if.test_logic_reset_o, 1'b1);
      chk("abort_dsel", tap_if.debug_select_o, 1'b0);
      chk("abort_oe",   tap_if.tdo_oe_o, 1'b0);
      trst = 1'b0;
      tick(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(idv[k]);
      dr_scan(8, 32'h0, 32'h0);

      // TMS reset from Pause-DR with a non-IDCODE instruction loaded
      ir_scan(4'b1111);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("tms5_pause", tap_if.pause_dr_o, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      chk("tms4_not_tlr", tap_if.test_logic_reset_o, 1'b0);
      tick(1'b1, 1'b0);
      chk("tms5_tlr", tap_if.test_logic_reset_o, 1'b1);
      tick(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(idv[k]);
      dr_scan(8, 32'h0, 32'h0);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
